// File: rtl/dram_bist_sequencer_pkg.sv
// Shared types and helpers for the distributed-RAM BIST sequencer (package dram_bist_pkg).
// Holds the FSM states, the pattern codes, the LFSR step and the pattern-bit function.
package dram_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PAT_ZERO  = 2'd0,
        PAT_ONE   = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_LFSR  = 2'd3
    } pattern_e;

    // Fibonacci x^5+x^3+1: state bit i holds sequence term n+i, so the new top bit is s[3]^s[0].
    localparam logic [4:0] LFSR_TAPS = 5'b01001;

    function automatic logic [4:0] lfsr_next(input logic [4:0] state);
        return {^(state & LFSR_TAPS), state[4:1]};
    endfunction

    function automatic logic pat_bit(input pattern_e pattern, input logic addr_lsb,
                                     input logic lfsr_bit);
        logic bit_val;
        case (pattern)
            PAT_ZERO:  bit_val = 1'b0;
            PAT_ONE:   bit_val = 1'b1;
            PAT_CHECK: bit_val = addr_lsb;
            default:   bit_val = lfsr_bit;
        endcase
        return bit_val;
    endfunction

endpackage

// File: rtl/dram_bist_sequencer_if.sv
// RAM-side bus between the BIST sequencer (master) and one 32x1 dual-port distributed RAM (slave).
interface dram_bist_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ram_a;
    logic              ram_d;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_dpra;
    logic              ram_dpo;

    modport master (output ram_a, output ram_d, output ram_we, output ram_dpra, input ram_dpo);
    modport slave  (input ram_a, input ram_d, input ram_we, input ram_dpra, output ram_dpo);
endinterface

// File: rtl/dram_bist_lfsr.sv
// 5-bit Fibonacci LFSR with synchronous load and advance; o_bit is the current sequence term.
module dram_bist_lfsr
    import dram_bist_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [4:0] i_seed,
    input  logic       i_adv,
    output logic       o_bit
);

    logic [4:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= 5'h01;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_adv) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_bit = r_state[0];

endmodule

// File: rtl/dram_bist_sequencer.sv
// BIST sequencer for one 32x1 dual-port distributed RAM: write a pattern, read it back, count mismatches.
// Optional macro DRAM_BIST_ERR_INJECT_EN adds i_inj_addr, whose written bit is inverted.
module dram_bist_sequencer
    import dram_bist_pkg::*;
#(
    parameter int         ADDR_W    = 5,
    parameter logic [4:0] LFSR_SEED = 5'h15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [1:0]            i_pattern,
`ifdef DRAM_BIST_ERR_INJECT_EN
    input  logic [ADDR_W-1:0]     i_inj_addr,
`endif
    dram_bist_sequencer_if.master io_ram,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [ADDR_W:0]       o_err_count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [4:0]        SEED_EFF  = (LFSR_SEED == 5'd0) ? 5'h01 : LFSR_SEED;
    // The write side runs one term ahead because pat(0) is issued straight from the seed.
    localparam logic [4:0]        SEED_NEXT = lfsr_next(SEED_EFF);

    state_e            r_state;
    pattern_e          r_pattern;
    logic [ADDR_W-1:0] r_ram_a;
    logic [ADDR_W-1:0] r_ram_dpra;
    logic              r_ram_d;
    logic              r_ram_we;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ADDR_W:0]   r_err_count;

    logic              w_start_run;
    logic              w_write_last;
    logic              w_wr_bit;
    logic              w_rd_bit;
    logic              w_mismatch;
    logic              w_inj_first;
    logic              w_inj_next;
    logic [ADDR_W-1:0] w_a_next;
    logic [ADDR_W:0]   w_err_next;

    assign w_start_run  = ((r_state == IDLE) || (r_state == DONE)) && i_start;
    assign w_write_last = (r_state == WRITE) && (r_ram_a == ADDR_MAX);
    assign w_a_next     = r_ram_a + 1'b1;
    assign w_mismatch   = io_ram.ram_dpo != pat_bit(r_pattern, r_ram_dpra[0], w_rd_bit);
    assign w_err_next   = r_err_count + {{ADDR_W{1'b0}}, w_mismatch};

`ifdef DRAM_BIST_ERR_INJECT_EN
    assign w_inj_first = (i_inj_addr == '0);
    assign w_inj_next  = (i_inj_addr == w_a_next);
`else
    assign w_inj_first = 1'b0;
    assign w_inj_next  = 1'b0;
`endif

    dram_bist_lfsr u_wr_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_start_run),
        .i_seed (SEED_NEXT),
        .i_adv  (r_state == WRITE),
        .o_bit  (w_wr_bit)
    );

    dram_bist_lfsr u_rd_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_write_last),
        .i_seed (SEED_EFF),
        .i_adv  (r_state == READ),
        .o_bit  (w_rd_bit)
    );

    always_ff @(posedge clk) begin
        // NOTE: only the control and output registers are reset; the RAM keeps its contents
        // and the next run rewrites every address before reading.
        if (rst) begin
            r_state     <= IDLE;
            r_pattern   <= PAT_ZERO;
            r_ram_a     <= '0;
            r_ram_dpra  <= '0;
            r_ram_d     <= 1'b0;
            r_ram_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_pattern   <= pattern_e'(i_pattern);
                        r_ram_a     <= '0;
                        r_ram_we    <= 1'b1;
                        r_ram_d     <= pat_bit(pattern_e'(i_pattern), 1'b0, SEED_EFF[0]) ^ w_inj_first;
                        r_err_count <= '0;
                        r_pass      <= 1'b0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (r_ram_a == ADDR_MAX) begin
                        r_ram_we   <= 1'b0;
                        r_ram_dpra <= '0;
                        r_state    <= READ;
                    end else begin
                        r_ram_a <= w_a_next;
                        r_ram_d <= pat_bit(r_pattern, w_a_next[0], w_wr_bit) ^ w_inj_next;
                    end
                end
                READ: begin
                    // DPO has had a full cycle to settle since DPRA moved.
                    r_err_count <= w_err_next;
                    r_ram_dpra  <= r_ram_dpra + 1'b1;
                    if (r_ram_dpra == ADDR_MAX) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_ram.ram_a    = r_ram_a;
    assign io_ram.ram_d    = r_ram_d;
    assign io_ram.ram_we   = r_ram_we;
    assign io_ram.ram_dpra = r_ram_dpra;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pass          = r_pass;
    assign o_err_count     = r_err_count;

endmodule

// File: tb/tb_dram_bist_sequencer.sv
// Self-checking bench: behavioural 32x1 dual-port RAM with stuck-at faults, an edge-count
// reference model of the sequencer outputs, randomized runs and pinned literal expectations.
module tb_dram_bist_sequencer;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              i_start   = 1'b0;
    logic [1:0]        i_pattern = 2'd0;
    logic [ADDR_W-1:0] inj_addr  = 5'd31;
    logic              o_busy;
    logic              o_done;
    logic              o_pass;
    logic [ADDR_W:0]   o_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    dram_bist_sequencer_if #(.ADDR_W(ADDR_W)) ram_bus ();

    dram_bist_sequencer #(.ADDR_W(ADDR_W), .LFSR_SEED(5'h15)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_pattern   (i_pattern),
`ifdef DRAM_BIST_ERR_INJECT_EN
        .i_inj_addr  (inj_addr),
`endif
        .io_ram      (ram_bus),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_pass      (o_pass),
        .o_err_count (o_err_count)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM: synchronous write, asynchronous read, optional stuck-at-0 bits.
    logic mem   [DEPTH];
    bit   stuck [DEPTH];

    always @(posedge clk) begin
        if (ram_bus.ram_we === 1'b1) mem[ram_bus.ram_a] <= ram_bus.ram_d;
    end
    assign ram_bus.ram_dpo = stuck[ram_bus.ram_dpra] ? 1'b0 : mem[ram_bus.ram_dpra];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference LFSR sequence from the recurrence a[n+5] = a[n+3] ^ a[n], a[0..4] = seed bits.
    bit seq [DEPTH+5];

    // Model: j counts edges since the start edge E0; -1 means freshly reset.
    int j     = -1;
    int m_pat = 0;
    int m_inj = -1;
    bit m_stuck [DEPTH];

    always @(posedge clk) begin
        if (rst) begin
            j = -1;
        end else if ((j == -1 || j == 2*DEPTH) && i_start === 1'b1) begin
            j       = 0;
            m_pat   = int'(i_pattern);
            m_stuck = stuck;
`ifdef DRAM_BIST_ERR_INJECT_EN
            m_inj   = int'(inj_addr);
`endif
        end else if (j >= 0 && j < 2*DEPTH) begin
            j++;
        end
    end

    function automatic bit exp_bit(int k);
        case (m_pat)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return k[0];
            default: return seq[k];
        endcase
    endfunction

    function automatic bit wr_bit(int k);
        return exp_bit(k) ^ (k == m_inj);
    endfunction

    function automatic int n_mismatch(int n);
        int c = 0;
        for (int k = 0; k < n; k++) begin
            if ((m_stuck[k] ? 1'b0 : wr_bit(k)) != exp_bit(k)) c++;
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (j == -1) begin
            check("rst_ram_a",    ram_bus.ram_a,    0);
            check("rst_ram_d",    ram_bus.ram_d,    0);
            check("rst_ram_we",   ram_bus.ram_we,   0);
            check("rst_ram_dpra", ram_bus.ram_dpra, 0);
            check("rst_busy",     o_busy,           0);
            check("rst_done",     o_done,           0);
            check("rst_pass",     o_pass,           0);
            check("rst_err",      o_err_count,      0);
        end else begin
            check("busy",   o_busy,         j < 2*DEPTH);
            check("done",   o_done,         j == 2*DEPTH);
            check("ram_we", ram_bus.ram_we, j < DEPTH);
            if (j < DEPTH) begin
                check("ram_a", ram_bus.ram_a, j);
                check("ram_d", ram_bus.ram_d, wr_bit(j));
            end
            if (j >= DEPTH && j < 2*DEPTH) check("ram_dpra", ram_bus.ram_dpra, j - DEPTH);
            check("err_count", o_err_count, n_mismatch(j > DEPTH ? j - DEPTH : 0));
            check("pass", o_pass, (j == 2*DEPTH) && (n_mismatch(DEPTH) == 0));
        end
    end

    task automatic do_run(input logic [1:0] pat, input int glitch_at, output int edges);
        @(negedge clk);
        i_start   = 1'b1;
        i_pattern = pat;
        edges     = 0;
        do begin
            @(negedge clk);
            edges++;
            i_start   = (edges == glitch_at);
            i_pattern = 2'($urandom);
        end while (o_done !== 1'b1 && edges < 200);
        i_start = 1'b0;
        check("done_reached", o_done, 1);
    endtask

    task automatic post_run(input string tag);
        int e;
        e = n_mismatch(DEPTH);
        check({tag, "_err"},  o_err_count, e);
        check({tag, "_pass"}, o_pass,      e == 0);
        for (int k = 0; k < DEPTH; k++) check({tag, "_ram"}, mem[k], wr_bit(k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         edges;
        int         v;
        int         last;
        int         cyc;
        int         pulses;
        logic [4:0] seed;

        seed = 5'h15;
        for (int i = 0; i < 5; i++) seq[i] = seed[i];
        for (int n = 0; n < DEPTH; n++) seq[n+5] = seq[n+3] ^ seq[n];
        v = 0;
        for (int i = 0; i < 8; i++) v |= int'(seq[i]) << i;
        check("lfsr_model_pin", v, 32'h75);

        for (int k = 0; k < DEPTH; k++) begin
            mem[k]   = 1'($urandom);
            stuck[k] = 1'b0;
        end

        // Reset for 3 cycles with start held high: must stay idle.
        rst     = 1'b1;
        i_start = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", o_busy, 0);
        check("reset_we",   ram_bus.ram_we, 0);
        rst     = 1'b0;
        i_start = 1'b0;
        @(negedge clk);

        do_run(2'd2, 0, edges);
        check("checker_latency", edges, 65);
        post_run("checker");
`ifndef DRAM_BIST_ERR_INJECT_EN
        check("checker_pass_lit", o_pass, 1);
        check("checker_err_lit",  o_err_count, 0);
        check("checker_ram5_lit", mem[5], 1);
`endif

        do_run(2'd3, 0, edges);
        post_run("lfsr");
        check("lfsr_ram6_lit", mem[6], 1);
        check("lfsr_ram7_lit", mem[7], 0);

        do_run(2'd1, 0, edges);
        post_run("ones");
`ifndef DRAM_BIST_ERR_INJECT_EN
        check("ones_pass_lit", o_pass, 1);
`endif

        stuck[7] = 1'b1;
        do_run(2'd1, 0, edges);
        post_run("stuck7");
`ifndef DRAM_BIST_ERR_INJECT_EN
        check("stuck7_err_lit",  o_err_count, 1);
        check("stuck7_pass_lit", o_pass, 0);
`endif

        for (int k = 0; k < DEPTH; k++) stuck[k] = 1'b1;
        do_run(2'd1, 0, edges);
        post_run("stuck_all");
        check("stuck_all_err_lit", o_err_count, 32);
        for (int k = 0; k < DEPTH; k++) stuck[k] = 1'b0;

        // Reset on the 10th WRITE cycle, then a clean run.
        @(negedge clk);
        i_start   = 1'b1;
        i_pattern = 2'd3;
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        check("midrun_busy_before", o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_we_after_rst",   ram_bus.ram_we, 0);
        check("midrun_busy_after_rst", o_busy, 0);
        rst = 1'b0;
        do_run(2'd2, 0, edges);
        post_run("after_rst");
`ifndef DRAM_BIST_ERR_INJECT_EN
        check("after_rst_pass_lit", o_pass, 1);
`endif

        // Start pulse during READ is ignored.
        do_run(2'd0, 40, edges);
        check("glitch_latency", edges, 65);
        post_run("glitch");

        // Start held high: back-to-back runs, one done pulse every 65 edges.
        @(negedge clk);
        i_start   = 1'b1;
        i_pattern = 2'($urandom);
        last      = -1;
        cyc       = 0;
        pulses    = 0;
        while (pulses < 3 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            i_pattern = 2'($urandom);
            if (o_done === 1'b1) begin
                if (last >= 0) check("b2b_gap", cyc - last, 65);
                last = cyc;
                pulses++;
            end
        end
        i_start = 1'b0;
        check("b2b_pulses", pulses, 3);

        // Randomized runs with sparse stuck-at faults and stray start pulses.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < DEPTH; k++) stuck[k] = ($urandom_range(0, 3) == 0);
            do_run(2'($urandom), $urandom_range(33, 62), edges);
            check("rand_latency", edges, 65);
            post_run("rand");
        end
        for (int k = 0; k < DEPTH; k++) stuck[k] = 1'b0;

`ifdef DRAM_BIST_ERR_INJECT_EN
        inj_addr = 5'd31;
        do_run(2'd0, 0, edges);
        post_run("inject");
        check("inject_ram31_lit", mem[31], 1);
        check("inject_err_lit",   o_err_count, 1);
        check("inject_pass_lit",  o_pass, 0);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
